// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and constants for the pipeline stage
package pipe_pkg;
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;
    localparam int NOP_MAX_W = 256;
    localparam logic [NOP_MAX_W-1:0] CTRL_NOP = '0;
endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// sat_counter: saturating event counter with synchronous clear
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] r_cnt;
    assign cnt = r_cnt;
    // clear has priority; otherwise count up and stick at all-ones
    always_ff @(posedge clk)
        if (!rst || clr) r_cnt <= '0;
        else if (inc && ~&r_cnt) r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with 2-entry skid, bubble insert and flush
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 10,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              bubble,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);
    state_t            r_state;
    logic [CTRL_W-1:0] r_m_ctrl, r_s_ctrl;
    logic [DATA_W-1:0] r_m_data, r_s_data;
    logic              w_room, w_xfer, w_enq, w_stall_inc, w_bub_inc;
    logic [CTRL_W-1:0] w_ctrl;

    // ready comes only from registered occupancy, so downstream ready never reaches upstream combinationally
    assign w_room      = r_state != FULL;
    assign in_ready    = w_room & ~bubble & rst;
    assign out_valid   = r_state != EMPTY;
    assign out_ctrl    = r_m_ctrl;
    assign out_data    = r_m_data;
    assign w_xfer      = out_valid & out_ready;
    assign w_enq       = (in_valid & in_ready) | (bubble & w_room);
    assign w_ctrl      = bubble ? CTRL_NOP[CTRL_W-1:0] : in_ctrl;
    assign w_stall_inc = out_valid & ~out_ready & ~flush;
    assign w_bub_inc   = bubble & w_room & ~flush;

    // occupancy and entry storage; main is the head, skid catches the second entry
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= EMPTY;
            r_m_ctrl <= '0;
            r_m_data <= '0;
        end else if (flush) begin
            r_state <= EMPTY;
        end else begin
            case (r_state)
                EMPTY: if (w_enq) begin
                    r_state  <= ONE;
                    r_m_ctrl <= w_ctrl;
                    r_m_data <= in_data;
                end
                ONE: if (w_enq && w_xfer) begin
                    r_m_ctrl <= w_ctrl;
                    r_m_data <= in_data;
                end else if (w_enq) begin
                    r_state  <= FULL;
                    r_s_ctrl <= w_ctrl;
                    r_s_data <= in_data;
                end else if (w_xfer) begin
                    r_state <= EMPTY;
                end
                FULL: if (w_xfer) begin
                    r_state  <= ONE;
                    r_m_ctrl <= r_s_ctrl;
                    r_m_data <= r_s_data;
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall (
        .clk (clk),
        .rst (rst),
        .inc (w_stall_inc),
        .clr (stat_clr),
        .cnt (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble (
        .clk (clk),
        .rst (rst),
        .inc (w_bub_inc),
        .clr (stat_clr),
        .cnt (bubble_cnt)
    );
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed and randomized checks of the skid stage against a queue model
module tb_pipe_stage_skid;
    localparam int CW = 10;
    localparam int DW = 128;
    localparam int EW = CW + DW;
    typedef logic [EW-1:0] ent_t;

    logic clk = 0, rst = 0, in_valid = 0, bubble = 0, flush = 0, out_ready = 0, stat_clr = 0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic in_ready, out_valid, in_ready2, out_valid2;
    logic [CW-1:0] out_ctrl, out_ctrl2;
    logic [DW-1:0] out_data, out_data2;
    logic [15:0] stall_cnt, bubble_cnt;
    logic [1:0] stall_cnt2, bubble_cnt2;

    int checks = 0, failures = 0;
    ent_t m_q[$];
    int m_stall = 0, m_bub = 0, m_stall2 = 0, m_bub2 = 0;

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .in_data(in_data), .bubble(bubble), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data), .stat_clr(stat_clr),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_ctrl(in_ctrl),
        .in_data(in_data), .bubble(bubble), .flush(flush), .out_valid(out_valid2),
        .out_ready(out_ready), .out_ctrl(out_ctrl2), .out_data(out_data2), .stat_clr(stat_clr),
        .stall_cnt(stall_cnt2), .bubble_cnt(bubble_cnt2)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int v, input bit inc, input int mx);
        return (inc && v < mx) ? v + 1 : v;
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                         input logic b, input logic f, input logic r);
        in_valid = v; in_ctrl = c; in_data = d; bubble = b; flush = f; out_ready = r; stat_clr = 0;
        #1;
    endtask

    // advance one clock, updating the queue model from the inputs present at the edge
    task automatic tick();
        int n;
        bit st, bu;
        ent_t e;
        n = m_q.size();
        st = n > 0 && !out_ready;
        bu = bubble && n < 2;
        e = {in_ctrl, in_data};
        if (bubble) e[EW-1 -: CW] = '0;
        if (!rst || stat_clr) begin
            m_stall = 0; m_bub = 0; m_stall2 = 0; m_bub2 = 0;
        end else if (!flush) begin
            m_stall = sat(m_stall, st, 65535); m_bub = sat(m_bub, bu, 65535);
            m_stall2 = sat(m_stall2, st, 3); m_bub2 = sat(m_bub2, bu, 3);
        end
        if (!rst || flush) m_q.delete();
        else begin
            if (n > 0 && out_ready) void'(m_q.pop_front());
            if ((in_valid && n < 2 && !bubble) || bu) m_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 0;
        drive(1, 10'h155, 128'h1234, 0, 0, 1);
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0) begin
            failures++; $display("FAIL reset_outputs got v=%b c=%h d=%h exp 0", out_valid, out_ctrl, out_data);
        end
        checks++;
        if (stall_cnt !== '0 || bubble_cnt !== '0) begin
            failures++; $display("FAIL reset_counters got s=%0d b=%0d exp 0", stall_cnt, bubble_cnt);
        end
        drive(0, 0, 0, 0, 0, 1);
        rst = 1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 8; i++) begin
            drive(1, CW'(i), DW'(i), 0, 0, 1);
            checks++;
            if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, in_ready); end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_ctrl !== CW'(i) || out_data !== DW'(i)) begin
                failures++;
                $display("FAIL stream_out[%0d] got v=%b c=%h d=%h exp v=1 c=%h d=%h", i, out_valid, out_ctrl, out_data, CW'(i), DW'(i));
            end
        end
        drive(0, 0, 0, 0, 0, 1);
        tick();
        checks++;
        if (out_valid !== 1'b0 || stall_cnt !== 16'd0) begin
            failures++; $display("FAIL stream_end got v=%b stall=%0d exp v=0 stall=0", out_valid, stall_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] d0, d1;
        d0 = rnd_data();
        d1 = rnd_data();
        drive(1, 10'h011, d0, 0, 0, 0);
        tick();
        drive(1, 10'h022, d1, 0, 0, 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1, 10'h033, rnd_data(), 0, 0, 0);
            checks++;
            if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_in_ready[%0d] got=%b exp=0", i, in_ready); end
            tick();
        end
        checks++;
        if (stall_cnt !== 16'd3) begin failures++; $display("FAIL bp_stall_cnt got=%0d exp=3", stall_cnt); end
        drive(0, 0, 0, 0, 0, 1);
        checks++;
        if (out_valid !== 1'b1 || out_ctrl !== 10'h011 || out_data !== d0) begin
            failures++; $display("FAIL bp_head0 got v=%b c=%h d=%h exp c=011 d=%h", out_valid, out_ctrl, out_data, d0);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_ctrl !== 10'h022 || out_data !== d1) begin
            failures++; $display("FAIL bp_head1 got v=%b c=%h d=%h exp c=022 d=%h", out_valid, out_ctrl, out_data, d1);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got v=%b exp=0", out_valid); end
    endtask

    task automatic test_bubble();
        logic [DW-1:0] d0;
        d0 = rnd_data();
        drive(1, 10'h005, d0, 0, 0, 0);
        tick();
        drive(1, 10'h3FF, 128'hABCD, 1, 0, 0);
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL bubble_in_ready got=%b exp=0", in_ready); end
        tick();
        checks++;
        if (bubble_cnt !== 16'd1) begin failures++; $display("FAIL bubble_cnt got=%0d exp=1", bubble_cnt); end
        drive(0, 0, 0, 0, 0, 1);
        checks++;
        if (out_ctrl !== 10'h005 || out_data !== d0) begin
            failures++; $display("FAIL bubble_head got c=%h d=%h exp c=005 d=%h", out_ctrl, out_data, d0);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_ctrl !== 10'h000 || out_data !== 128'hABCD) begin
            failures++; $display("FAIL bubble_nop got v=%b c=%h d=%h exp v=1 c=000 d=abcd", out_valid, out_ctrl, out_data);
        end
        tick();
    endtask

    task automatic test_bubble_full();
        logic [DW-1:0] da, db, dc;
        da = rnd_data(); db = rnd_data(); dc = rnd_data();
        drive(1, 10'h0A1, da, 0, 0, 0);
        tick();
        drive(1, 10'h0B2, db, 0, 0, 0);
        tick();
        drive(0, 10'h3FF, dc, 1, 0, 0);
        tick();
        checks++;
        if (bubble_cnt !== 16'd1 || out_ctrl !== 10'h0A1) begin
            failures++; $display("FAIL bfull_hold got bcnt=%0d c=%h exp bcnt=1 c=0a1", bubble_cnt, out_ctrl);
        end
        drive(0, 10'h3FF, dc, 1, 0, 1);
        tick();
        checks++;
        if (bubble_cnt !== 16'd1 || out_ctrl !== 10'h0B2 || out_data !== db) begin
            failures++; $display("FAIL bfull_xfer got bcnt=%0d c=%h d=%h exp bcnt=1 c=0b2 d=%h", bubble_cnt, out_ctrl, out_data, db);
        end
        drive(0, 10'h3FF, dc, 1, 0, 0);
        tick();
        checks++;
        if (bubble_cnt !== 16'd2) begin failures++; $display("FAIL bfull_enq got bcnt=%0d exp=2", bubble_cnt); end
        drive(0, 0, 0, 0, 0, 1);
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_ctrl !== 10'h000 || out_data !== dc) begin
            failures++; $display("FAIL bfull_nop got v=%b c=%h d=%h exp v=1 c=000 d=%h", out_valid, out_ctrl, out_data, dc);
        end
        tick();
    endtask

    task automatic test_flush();
        drive(1, 10'h0C1, rnd_data(), 0, 0, 0);
        tick();
        drive(1, 10'h0C2, rnd_data(), 0, 0, 0);
        tick();
        drive(1, 10'h0DD, 128'hDEAD, 0, 1, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL flush_next got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++; $display("FAIL flush_dropped[%0d] got v=%b c=%h exp v=0", i, out_valid, out_ctrl);
            end
        end
    endtask

    task automatic test_saturation();
        drive(0, 0, 0, 0, 0, 1);
        stat_clr = 1;
        tick();
        drive(1, 10'h0E1, rnd_data(), 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (stall_cnt2 !== 2'd3 || stall_cnt !== 16'd6) begin
            failures++; $display("FAIL sat_stall got s2=%0d s16=%0d exp s2=3 s16=6", stall_cnt2, stall_cnt);
        end
        stat_clr = 1;
        tick();
        checks++;
        if (stall_cnt2 !== 2'd0 || stall_cnt !== 16'd0) begin
            failures++; $display("FAIL sat_clr got s2=%0d s16=%0d exp 0", stall_cnt2, stall_cnt);
        end
        drive(0, 0, 0, 0, 0, 1);
        tick();
    endtask

    task automatic test_random();
        bit exp_v;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(99) != 0);
            drive($urandom_range(1), CW'($urandom), rnd_data(), $urandom_range(7) == 0,
                  $urandom_range(31) == 0, $urandom_range(9) < 6);
            stat_clr = $urandom_range(63) == 0;
            #1;
            checks++;
            if (in_ready !== (rst && m_q.size() < 2 && !bubble) || in_ready2 !== in_ready) begin
                failures++; $display("FAIL rnd_in_ready[%0d] got=%b/%b exp=%b", i, in_ready, in_ready2, rst && m_q.size() < 2 && !bubble);
            end
            tick();
            exp_v = m_q.size() > 0;
            checks++;
            if (out_valid !== exp_v || (exp_v && {out_ctrl, out_data} !== m_q[0])) begin
                failures++; $display("FAIL rnd_out[%0d] got v=%b c=%h d=%h exp v=%b", i, out_valid, out_ctrl, out_data, exp_v);
            end
            checks++;
            if (out_valid2 !== exp_v || (exp_v && {out_ctrl2, out_data2} !== m_q[0])) begin
                failures++; $display("FAIL rnd_out2[%0d] got v=%b c=%h exp v=%b", i, out_valid2, out_ctrl2, exp_v);
            end
            checks++;
            if (stall_cnt !== 16'(m_stall) || bubble_cnt !== 16'(m_bub) ||
                stall_cnt2 !== 2'(m_stall2) || bubble_cnt2 !== 2'(m_bub2)) begin
                failures++;
                $display("FAIL rnd_cnt[%0d] got s=%0d b=%0d s2=%0d b2=%0d exp s=%0d b=%0d s2=%0d b2=%0d",
                         i, stall_cnt, bubble_cnt, stall_cnt2, bubble_cnt2, m_stall, m_bub, m_stall2, m_bub2);
            end
        end
        rst = 1;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble();
        test_bubble_full();
        test_flush();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout run did not complete");
        $fatal(1);
    end
endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline-stage register for the CPU datapath, the generalised successor to the fixed inter-stage registers. It carries a control field and a data field between stages with a valid/ready handshake and a 2-entry skid buffer, so upstream never sees a combinational ready path from downstream. Hazard bubbles are inserted by zeroing only the control field, and a flush empties the stage. Saturating counters for stall cycles and inserted bubbles feed the performance registers.

## Interface
- CTRL_W, 10, width of control field (RegWrite, MemWrite, MemRead, etc.); forced to zero on a bubble
- DATA_W, 128, width of pass-through data field (ALU operands, PC, store data)
- CNT_W, 16, width of each performance counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept; `(state != FULL) & ~bubble & rst`
- in_ctrl  in  CTRL_W  upstream control field
- in_data  in  DATA_W  upstream data field
- bubble  in  1  hazard: hold upstream, enqueue a NOP entry
- flush  in  1  discard all held entries and any concurrent input
- out_valid  out  1  head entry present
- out_ready  in  1  downstream accepts head
- out_ctrl  out  CTRL_W  head control field
- out_data  out  DATA_W  head data field
- stat_clr  in  1  zero both counters
- stall_cnt  out  CNT_W  cycles with out_valid & ~out_ready
- bubble_cnt  out  CNT_W  NOP entries enqueued

## Operation
- Storage: main entry (head, drives outputs) and skid entry. Each entry holds ctrl, data, and a valid bit.
- States: EMPTY (no entries), ONE (main only), FULL (main and skid).
- Definitions:
  - out_xfer = out_valid & out_ready.
  - enq = (in_valid & in_ready) | (bubble & state != FULL).
  - Enqueued ctrl = bubble ? CTRL_NOP (all zero) : in_ctrl. Enqueued data is always in_data.
- Transitions, in priority order:
  - rst low: go to EMPTY.
  - flush: go to EMPTY. Concurrent enq and out_xfer are dropped, and counters do not advance for that cycle.
  - EMPTY: enq moves to ONE with main = new entry.
  - ONE: enq with out_xfer stays in ONE with main = new entry. enq alone moves to FULL with skid = new entry. out_xfer alone moves to EMPTY.
  - FULL: out_xfer moves to ONE with main = skid. No enq is possible in this state.
- A bubble with state FULL enqueues nothing and is not counted. Upstream stays held while bubble is high.
- Counters saturate at 2^CNT_W-1. stat_clr wins over an increment in the same cycle.
- out_ctrl and out_data are held stable while out_valid & ~out_ready.

## Timing
- Reset values: out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, bubble_cnt=0, state EMPTY. in_ready=0 while rst is low, 1 in the first cycle after release.
- Latency: an input accepted in cycle N appears on the outputs in cycle N+1. Throughput is 1 entry per cycle when out_ready stays high.
- in_ready depends only on registered state, bubble, and rst. There is no out_ready→in_ready combinational path.
- After flush in cycle N: out_valid=0 and in_ready=1 in cycle N+1, provided bubble is low.

## Structure
- Package pipe_pkg holds:
  - state enum {EMPTY, ONE, FULL}
  - CTRL_NOP constant (all zero, sized by CTRL_W at use)
  - entry struct typedef, if the team's flow supports parametrised structs; otherwise separate ctrl/data/valid vectors
- Sub-module sat_counter (parameter CNT_W; inputs inc, clr) is instantiated twice, once per counter.

## Test plan
- Reset, then stream 8 entries (ctrl=i, data=i) with out_ready=1 → each output appears 1 cycle after input in order, in_ready stays 1, stall_cnt=0.
- Stream with out_ready=0 for 3 cycles → state reaches FULL after 2 accepts, in_ready=0, stall_cnt=3. On out_ready=1, entries drain in order with none lost or duplicated.
- bubble=1 for 1 cycle in ONE with in_ctrl=0x3FF, in_data=0xABCD → next output entry has ctrl=0 and data=0xABCD, in_ready=0 that cycle, bubble_cnt=1.
- bubble=1 while FULL → no NOP is enqueued and bubble_cnt is unchanged. After one out_xfer the NOP enqueues.
- flush asserted together with in_valid and out_ready in FULL → next cycle out_valid=0, in_ready=1, and the dropped input never appears on the outputs.
- CNT_W=2 with stall held for 6 cycles → stall_cnt saturates at 3. stat_clr together with a stall cycle → stall_cnt=0.
